axi_4_lite_arb2: RTL and testbench

AXI_4_LITE_ARB2 -- requirements
Module: axi_4_lite_arb2

---
 rtl/axi_4_lite_arb2_pkg.sv | 30 +++
 rtl/rr_arb2.sv | 18 +
 rtl/axi_4_lite_arb2.sv | 207 ++++++++++++++++++++
 tb/tb_axi_4_lite_arb2.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_4_lite_arb2_pkg.sv
// Shared AXI4-Lite configuration: bus width macros, arbiter FSM encodings and response codes.
`ifndef C_AXI_ADDR_WIDTH
`define C_AXI_ADDR_WIDTH 32
`endif
`ifndef C_AXI_DATA_WIDTH
`define C_AXI_DATA_WIDTH 32
`endif
`ifndef C_AXI_STROBE_WIDTH
`define C_AXI_STROBE_WIDTH (`C_AXI_DATA_WIDTH / 8)
`endif

package axi_4_lite_arb2_pkg;

    localparam int unsigned AW = `C_AXI_ADDR_WIDTH;
    localparam int unsigned DW = `C_AXI_DATA_WIDTH;
    localparam int unsigned SW = `C_AXI_STROBE_WIDTH;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StWr     = 3'd1,
        StWrResp = 3'd2,
        StRdAddr = 3'd3,
        StRdData = 3'd4,
        StDone   = 3'd5
    } arb_state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: on a tie the requester not granted last wins.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/axi_4_lite_arb2.sv
// Two-requester round-robin front end onto one AXI4-Lite master port, one transaction at a time.
// Define ARB_TIMEOUT_EN to add a slave-response watchdog that completes with SLVERR.
module axi_4_lite_arb2
    import axi_4_lite_arb2_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic            S_AXI_ACLK,
    input  logic            S_AXI_ARESETN,
    input  logic [1:0]      REQ_VALID,
    output logic [1:0]      REQ_READY,
    input  logic [1:0]      REQ_WE,
    input  logic [2*AW-1:0] REQ_ADDR,
    input  logic [2*DW-1:0] REQ_WDATA,
    input  logic [2*SW-1:0] REQ_WSTRB,
    output logic [1:0]      RSP_VALID,
    output logic [DW-1:0]   RSP_RDATA,
    output logic [1:0]      RSP_RESP,
    output logic            M_AXI_AWVALID,
    input  logic            M_AXI_AWREADY,
    output logic [AW-1:0]   M_AXI_AWADDR,
    output logic [2:0]      M_AXI_AWPROT,
    output logic            M_AXI_WVALID,
    input  logic            M_AXI_WREADY,
    output logic [DW-1:0]   M_AXI_WDATA,
    output logic [SW-1:0]   M_AXI_WSTRB,
    input  logic            M_AXI_BVALID,
    output logic            M_AXI_BREADY,
    input  logic [1:0]      M_AXI_BRESP,
    output logic            M_AXI_ARVALID,
    input  logic            M_AXI_ARREADY,
    output logic [AW-1:0]   M_AXI_ARADDR,
    output logic [2:0]      M_AXI_ARPROT,
    input  logic            M_AXI_RVALID,
    output logic            M_AXI_RREADY,
    input  logic [DW-1:0]   M_AXI_RDATA,
    input  logic [1:0]      M_AXI_RRESP
);

    if (TIMEOUT_CYCLES < 2) begin : gen_timeout_cfg_err
        $error("TIMEOUT_CYCLES must be at least 2");
    end

    arb_state_e    state_q, state_d;
    logic          last_q, last_d;
    logic          gidx_q, gidx_d;
    logic          aw_pend_q, aw_pend_d;
    logic          w_pend_q, w_pend_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [SW-1:0] wstrb_q, wstrb_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic [1:0]    resp_q, resp_d;
    logic [1:0]    grant;
    logic [1:0]    req_ready;
    logic          sel;

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            busy;

    assign busy = (state_q == StWr) || (state_q == StWrResp) ||
                  (state_q == StRdAddr) || (state_q == StRdData);
`endif

    rr_arb2 u_rr_arb2 (
        .req   (REQ_VALID),
        .last  (last_q),
        .grant (grant)
    );

    assign sel = grant[1];

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        gidx_d    = gidx_q;
        aw_pend_d = aw_pend_q;
        w_pend_d  = w_pend_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        rdata_d   = rdata_q;
        resp_d    = resp_q;
        req_ready = 2'b00;

        case (state_q)
            StIdle: begin
                if (|REQ_VALID) begin
                    req_ready = grant;
                    gidx_d    = sel;
                    last_d    = sel;
                    addr_d    = sel ? REQ_ADDR[2*AW-1:AW]   : REQ_ADDR[AW-1:0];
                    wdata_d   = sel ? REQ_WDATA[2*DW-1:DW]  : REQ_WDATA[DW-1:0];
                    wstrb_d   = sel ? REQ_WSTRB[2*SW-1:SW]  : REQ_WSTRB[SW-1:0];
                    if (REQ_WE[sel]) begin
                        state_d   = StWr;
                        aw_pend_d = 1'b1;
                        w_pend_d  = 1'b1;
                    end else begin
                        state_d = StRdAddr;
                    end
                end
            end
            StWr: begin
                // AW and W complete independently; leave once neither is still pending.
                if (M_AXI_AWREADY) aw_pend_d = 1'b0;
                if (M_AXI_WREADY)  w_pend_d  = 1'b0;
                if ((!aw_pend_q || M_AXI_AWREADY) && (!w_pend_q || M_AXI_WREADY)) begin
                    state_d = StWrResp;
                end
            end
            StWrResp: begin
                if (M_AXI_BVALID) begin
                    resp_d  = M_AXI_BRESP;
                    rdata_d = '0;
                    state_d = StDone;
                end
            end
            StRdAddr: begin
                if (M_AXI_ARREADY) state_d = StRdData;
            end
            StRdData: begin
                if (M_AXI_RVALID) begin
                    resp_d  = M_AXI_RRESP;
                    rdata_d = M_AXI_RDATA;
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

`ifdef ARB_TIMEOUT_EN
        cnt_d = cnt_q;
        if (state_q == StIdle) begin
            cnt_d = '0;
        end else if (busy) begin
            cnt_d = cnt_q + 1'b1;
            // A transaction finishing on the limit cycle keeps its real response.
            if ((cnt_q == CntW'(TIMEOUT_CYCLES - 1)) && (state_d != StDone)) begin
                state_d   = StDone;
                resp_d    = RESP_SLVERR;
                rdata_d   = '0;
                aw_pend_d = 1'b0;
                w_pend_d  = 1'b0;
            end
        end
`endif
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            state_q   <= StIdle;
            last_q    <= 1'b1;
            gidx_q    <= 1'b0;
            aw_pend_q <= 1'b0;
            w_pend_q  <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            rdata_q   <= '0;
            resp_q    <= RESP_OKAY;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            gidx_q    <= gidx_d;
            aw_pend_q <= aw_pend_d;
            w_pend_q  <= w_pend_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            rdata_q   <= rdata_d;
            resp_q    <= resp_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    // Grant is combinational on REQ_VALID, so it must be masked while reset is held.
    assign REQ_READY     = req_ready & {2{S_AXI_ARESETN}};
    assign RSP_VALID     = (state_q == StDone) ? {gidx_q, ~gidx_q} : 2'b00;
    assign RSP_RDATA     = rdata_q;
    assign RSP_RESP      = resp_q;

    assign M_AXI_AWVALID = aw_pend_q;
    assign M_AXI_AWADDR  = addr_q;
    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_WVALID  = w_pend_q;
    assign M_AXI_WDATA   = wdata_q;
    assign M_AXI_WSTRB   = wstrb_q;
    assign M_AXI_BREADY  = (state_q == StWrResp);
    assign M_AXI_ARVALID = (state_q == StRdAddr);
    assign M_AXI_ARADDR  = addr_q;
    assign M_AXI_ARPROT  = 3'b000;
    assign M_AXI_RREADY  = (state_q == StRdData);

endmodule

// File: tb/tb_axi_4_lite_arb2.sv
// Bench for axi_4_lite_arb2: requester driver, AXI4-Lite memory slave model, directed vectors.
module tb_axi_4_lite_arb2;
    import axi_4_lite_arb2_pkg::*;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [1:0]      REQ_VALID = '0;
    logic [1:0]      REQ_READY;
    logic [1:0]      REQ_WE = '0;
    logic [2*AW-1:0] REQ_ADDR = '0;
    logic [2*DW-1:0] REQ_WDATA = '0;
    logic [2*SW-1:0] REQ_WSTRB = '0;
    logic [1:0]      RSP_VALID;
    logic [DW-1:0]   RSP_RDATA;
    logic [1:0]      RSP_RESP;
    logic            awvalid, awready, wvalid, wready, bvalid, bready;
    logic            arvalid, arready, rvalid, rready;
    logic [AW-1:0]   awaddr, araddr;
    logic [2:0]      awprot, arprot;
    logic [DW-1:0]   wdata, rdata;
    logic [SW-1:0]   wstrb;
    logic [1:0]      bresp, rresp;

    always #5 clk = ~clk;

    axi_4_lite_arb2 #(.TIMEOUT_CYCLES(16)) dut (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESETN (rst_n),
        .REQ_VALID     (REQ_VALID),
        .REQ_READY     (REQ_READY),
        .REQ_WE        (REQ_WE),
        .REQ_ADDR      (REQ_ADDR),
        .REQ_WDATA     (REQ_WDATA),
        .REQ_WSTRB     (REQ_WSTRB),
        .RSP_VALID     (RSP_VALID),
        .RSP_RDATA     (RSP_RDATA),
        .RSP_RESP      (RSP_RESP),
        .M_AXI_AWVALID (awvalid),
        .M_AXI_AWREADY (awready),
        .M_AXI_AWADDR  (awaddr),
        .M_AXI_AWPROT  (awprot),
        .M_AXI_WVALID  (wvalid),
        .M_AXI_WREADY  (wready),
        .M_AXI_WDATA   (wdata),
        .M_AXI_WSTRB   (wstrb),
        .M_AXI_BVALID  (bvalid),
        .M_AXI_BREADY  (bready),
        .M_AXI_BRESP   (bresp),
        .M_AXI_ARVALID (arvalid),
        .M_AXI_ARREADY (arready),
        .M_AXI_ARADDR  (araddr),
        .M_AXI_ARPROT  (arprot),
        .M_AXI_RVALID  (rvalid),
        .M_AXI_RREADY  (rready),
        .M_AXI_RDATA   (rdata),
        .M_AXI_RRESP   (rresp)
    );

    // Memory slave: 16 words below 0x40, SLVERR above.
    logic [DW-1:0] mem [16];
    logic          aw_got, w_got, phase;
    logic          slow = 1'b0, b_stall = 1'b0, aw_block = 1'b0;
    logic [AW-1:0] aw_addr;
    logic [DW-1:0] w_data;
    logic [SW-1:0] w_strb;

    assign awready = !aw_got && !aw_block && (!slow || phase);
    assign wready  = !w_got && (!slow || !phase);
    assign arready = !rvalid && (!slow || phase);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_got <= 1'b0;
            w_got  <= 1'b0;
            bvalid <= 1'b0;
            rvalid <= 1'b0;
            phase  <= 1'b0;
            bresp  <= 2'b00;
            rresp  <= 2'b00;
            rdata  <= '0;
        end else begin
            phase <= !phase;
            if (awvalid && awready) begin
                aw_got  <= 1'b1;
                aw_addr <= awaddr;
            end
            if (wvalid && wready) begin
                w_got  <= 1'b1;
                w_data <= wdata;
                w_strb <= wstrb;
            end
            if (aw_got && w_got && !bvalid && !b_stall) begin
                bvalid <= 1'b1;
                aw_got <= 1'b0;
                w_got  <= 1'b0;
                if (aw_addr < AW'(32'h40)) begin
                    bresp <= 2'b00;
                    for (int b = 0; b < SW; b++) begin
                        if (w_strb[b]) mem[aw_addr[5:2]][b*8 +: 8] <= w_data[b*8 +: 8];
                    end
                end else begin
                    bresp <= 2'b10;
                end
            end
            if (bvalid && bready) bvalid <= 1'b0;
            if (arvalid && arready) begin
                rvalid <= 1'b1;
                if (araddr < AW'(32'h40)) begin
                    rdata <= mem[araddr[5:2]];
                    rresp <= 2'b00;
                end else begin
                    rdata <= '0;
                    rresp <= 2'b10;
                end
            end
            if (rvalid && rready) rvalid <= 1'b0;
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic expire(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    task automatic drive(input int id, input logic we, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [SW-1:0] s);
        REQ_WE[id]              = we;
        REQ_ADDR[id*AW +: AW]   = a;
        REQ_WDATA[id*DW +: DW]  = d;
        REQ_WSTRB[id*SW +: SW]  = s;
        REQ_VALID[id]           = 1'b1;
    endtask

    task automatic do_txn(input string tag, input int id, input logic we,
                          input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic [SW-1:0] s, input logic [DW-1:0] exp_rdata,
                          input logic [1:0] exp_resp);
        int n;
        @(negedge clk);
        drive(id, we, a, d, s);
        #1;
        n = 0;
        while (!REQ_READY[id] && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!REQ_READY[id]) begin
            expire({tag, "_grant"});
            REQ_VALID[id] = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        REQ_VALID[id] = 1'b0;
        @(negedge clk);
        check({tag, "_issue"}, 64'(we ? (awvalid & wvalid) : arvalid), 64'(1));
        n = 0;
        while (!RSP_VALID[id] && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!RSP_VALID[id]) begin
            expire({tag, "_rsp"});
            return;
        end
        check({tag, "_rdata"}, 64'(RSP_RDATA), 64'(exp_rdata));
        check({tag, "_resp"}, 64'(RSP_RESP), 64'(exp_resp));
        @(negedge clk);
        check({tag, "_pulse"}, 64'(RSP_VALID), 64'(0));
    endtask

    typedef struct {
        int            id;
        logic          we;
        logic [31:0]   addr;
        logic [31:0]   wdata;
        logic [3:0]    strb;
        logic          slow;
        logic [31:0]   exp_rdata;
        logic [1:0]    exp_resp;
    } vec_t;

    vec_t vecs [13];

    initial begin
        int n;
        int ngr;
        int rsp_seen;
        int glog [4];

        vecs[0]  = '{0, 1'b1, 32'h04, 32'hDEADBEEF, 4'hF, 1'b0, 32'h0,        2'b00};
        vecs[1]  = '{0, 1'b0, 32'h04, 32'h0,        4'h0, 1'b0, 32'hDEADBEEF, 2'b00};
        vecs[2]  = '{1, 1'b1, 32'h08, 32'hFFFFFFFF, 4'hF, 1'b0, 32'h0,        2'b00};
        vecs[3]  = '{1, 1'b1, 32'h08, 32'h12345678, 4'h3, 1'b0, 32'h0,        2'b00};
        vecs[4]  = '{0, 1'b0, 32'h08, 32'h0,        4'h0, 1'b0, 32'hFFFF5678, 2'b00};
        vecs[5]  = '{0, 1'b1, 32'h0C, 32'h00000000, 4'hF, 1'b1, 32'h0,        2'b00};
        vecs[6]  = '{1, 1'b1, 32'h0C, 32'hA5A5A5A5, 4'hC, 1'b1, 32'h0,        2'b00};
        vecs[7]  = '{1, 1'b0, 32'h0C, 32'h0,        4'h0, 1'b1, 32'hA5A50000, 2'b00};
        vecs[8]  = '{1, 1'b0, 32'h18, 32'h0,        4'h0, 1'b0, 32'h0F0F0F0F, 2'b00};
        vecs[9]  = '{0, 1'b0, 32'h1C, 32'h0,        4'h0, 1'b0, 32'hF0F0F0F0, 2'b00};
        vecs[10] = '{0, 1'b1, 32'h40, 32'h11111111, 4'hF, 1'b0, 32'h0,        RESP_SLVERR};
        vecs[11] = '{1, 1'b0, 32'h44, 32'h0,        4'h0, 1'b0, 32'h0,        RESP_SLVERR};
        vecs[12] = '{0, 1'b0, 32'h0C, 32'h0,        4'h0, 1'b1, 32'hA5A50000, 2'b00};

        // Reset values, with both requesters already asking.
        REQ_VALID = 2'b11;
        #12;
        check("rst_outputs", 64'({REQ_READY, RSP_VALID, RSP_RDATA, RSP_RESP, awvalid, wvalid,
                                   bready, arvalid, rready}), 64'(0));
        check("prot", 64'({awprot, arprot}), 64'(0));
        REQ_VALID = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;

        // Both requesters held valid for four grants.
        @(negedge clk);
        drive(0, 1'b1, 32'h18, 32'h0F0F0F0F, 4'hF);
        drive(1, 1'b1, 32'h1C, 32'hF0F0F0F0, 4'hF);
        ngr = 0;
        n = 0;
        while (ngr < 4 && n < 200) begin
            #1;
            if (REQ_READY != 2'b00) begin
                check($sformatf("rr_onehot%0d", ngr), 64'(REQ_READY == 2'b11), 64'(0));
                glog[ngr] = int'(REQ_READY[1]);
                ngr++;
            end
            @(negedge clk);
            n++;
        end
        REQ_VALID = 2'b00;
        if (ngr < 4) expire("rr_grants");
        for (int i = 0; i < ngr; i++) check($sformatf("rr_order%0d", i), 64'(glog[i]), 64'(i % 2));
        n = 0;
        while (!RSP_VALID[1] && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!RSP_VALID[1]) expire("rr_last_rsp");

        for (int i = 0; i < 13; i++) begin
            slow = vecs[i].slow;
            do_txn($sformatf("v%0d", i), vecs[i].id, vecs[i].we, vecs[i].addr, vecs[i].wdata,
                   vecs[i].strb, vecs[i].exp_rdata, vecs[i].exp_resp);
        end
        slow = 1'b0;

        // Reset while waiting in WR_RESP, requester 0 still asserting valid.
        b_stall = 1'b1;
        @(negedge clk);
        drive(0, 1'b1, 32'h14, 32'h55555555, 4'hF);
        #1;
        n = 0;
        while (!REQ_READY[0] && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!REQ_READY[0]) expire("mr_grant");
        n = 0;
        while (!bready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bready) expire("mr_bready");
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("mr_outputs", 64'({RSP_VALID, RSP_RDATA, RSP_RESP, awvalid, wvalid, bready,
                                  arvalid, rready}), 64'(0));
        check("mr_req_ready", 64'(REQ_READY), 64'(0));
        REQ_VALID = 2'b00;
        b_stall = 1'b0;
        rsp_seen = 0;
        repeat (2) begin
            @(negedge clk);
            if (RSP_VALID != 2'b00) rsp_seen++;
        end
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (RSP_VALID != 2'b00) rsp_seen++;
        end
        check("mr_no_rsp", 64'(rsp_seen), 64'(0));

        // Tie right after reset goes to requester 0 even though it was granted last.
        drive(0, 1'b0, 32'h04, 32'h0, 4'h0);
        drive(1, 1'b0, 32'h08, 32'h0, 4'h0);
        #1;
        n = 0;
        while (REQ_READY == 2'b00 && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("mr_tie_grant", 64'(REQ_READY), 64'(2'b01));
        @(posedge clk);
        #1;
        REQ_VALID = 2'b00;
        n = 0;
        while (!RSP_VALID[0] && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!RSP_VALID[0]) expire("mr_rsp");
        else check("mr_rdata", 64'(RSP_RDATA), 64'(32'hDEADBEEF));

`ifdef ARB_TIMEOUT_EN
        aw_block = 1'b1;
        @(negedge clk);
        drive(0, 1'b1, 32'h20, 32'h77777777, 4'hF);
        #1;
        n = 0;
        while (!REQ_READY[0] && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!REQ_READY[0]) expire("to_grant");
        @(posedge clk);
        #1;
        REQ_VALID = 2'b00;
        @(negedge clk);
        check("to_awvalid", 64'(awvalid), 64'(1));
        n = 0;
        while (!RSP_VALID[0] && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("to_latency", 64'(n), 64'(16));
        check("to_resp", 64'(RSP_RESP), 64'(RESP_SLVERR));
        check("to_rdata", 64'(RSP_RDATA), 64'(0));
        check("to_dropped", 64'({awvalid, wvalid, bready, arvalid, rready}), 64'(0));
        aw_block = 1'b0;
        do_txn("to_after", 1, 1'b0, 32'h04, 32'h0, 4'h0, 32'hDEADBEEF, 2'b00);
`endif

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
